// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner:
// glyph table, segment constants and the scan FSM state type.
package disp_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SNAP     = 2'd1,
    BLANKING = 2'd2,
    SHOW     = 2'd3
  } state_t;

  // Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high here;
  // polarity is applied only at the output registers of the top level.
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Digits 0-9 map to the usual glyphs; codes A-F are not valid BCD and
  // show a dash so a corrupted counter is visible rather than misleading.
  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'h3F,    // 0
    7'h06,    // 1
    7'h5B,    // 2
    7'h4F,    // 3
    7'h66,    // 4
    7'h6D,    // 5
    7'h7D,    // 6
    7'h07,    // 7
    7'h7F,    // 8
    7'h6F,    // 9
    SEG_DASH, // A
    SEG_DASH, // B
    SEG_DASH, // C
    SEG_DASH, // D
    SEG_DASH, // E
    SEG_DASH  // F
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high 7-segment glyph decoder.
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; invalid codes resolve to a dash inside the table.
  always_comb begin
    seg = SEG_GLYPH[bcd];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode 7-segment display scanner. Takes a frame
// snapshot of the BCD digit bank, then lights one digit at a time from the
// most significant down, with a dark gap at the start of every digit slot.
module bcd_display_scan
  import disp_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  // Prescaler counts the whole slot (blank + lit) and wraps at PRESCALE-1.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_TOP    = IW'(DIGITS - 1);

  // Pin-level inactive levels; XOR masks turn active-high into pin polarity.
  localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_POL  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{SEG_ACTIVE_LOW}};

  // Whether the slot sequence includes a dark phase at all.
  localparam state_t SLOT_FIRST = (BLANK > 0) ? BLANKING : SHOW;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Frame snapshot: digits, decimal points and leading-zero blank mask.
  logic [4*DIGITS-1:0]   snap_dig_q, snap_dig_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]     snap_lz_q, snap_lz_d;

  // Output registers, already in pin polarity.
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick_q, tick_d;

  // Leading-zero mask from the live inputs; captured only at snapshot time.
  logic [DIGITS-1:0]     upper_zero;
  logic [DIGITS-1:0]     lz_mask;

  // Digit currently being driven and its active-high glyph.
  logic [3:0]            digit_cur;
  logic [6:0]            glyph_cur;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  logic [DIGITS-1:0]     an_hi;

  // Digit k may be blanked only when it and every more significant digit
  // are zero; digit 0 is never blanked so a zero value still shows "0".
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = (digits[4*DIGITS-1:4*gi] == '0);
    if (gi == 0) begin : g_lsd
      assign lz_mask[gi] = 1'b0;
    end else begin : g_upper
      assign lz_mask[gi] = lz_blank & upper_zero[gi];
    end
  end

  // Scan FSM, slot prescaler, digit index and snapshot capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;

    if (!en) begin
      // Dropping enable abandons the frame; no partial slot is finished.
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SNAP;
        end
        SNAP: begin
          idx_d   = IDX_TOP;
          cnt_d   = '0;
          state_d = SLOT_FIRST;
        end
        BLANKING: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == '0) begin
              state_d = SNAP;
            end else begin
              idx_d   = idx_q - IW'(1);
              state_d = SLOT_FIRST;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // The snapshot is taken on the edge that enters SNAP, so it is stable
    // for the whole frame and mid-frame input changes cannot tear it.
    if (state_d == SNAP) begin
      snap_dig_d = digits;
      snap_dp_d  = dp_in;
      snap_lz_d  = lz_mask;
    end
  end

  // Select the digit that the next cycle will display.
  assign digit_cur = snap_dig_q[4*idx_d +: 4];

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_cur),
    .seg (glyph_cur)
  );

  // Output values follow the state being entered, so the pins change on
  // the same edge as the state register; polarity is applied last.
  always_comb begin
    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    an_hi  = '0;
    if (state_d == SHOW) begin
      // A blanked leading zero still pulses its anode for even brightness
      // and still honours its decimal point.
      an_hi  = DIGITS'(1) << idx_d;
      seg_hi = snap_lz_q[idx_d] ? SEG_OFF : glyph_cur;
      dp_hi  = snap_dp_q[idx_d];
    end
    seg_d  = seg_hi ^ SEG_POL;
    dp_d   = dp_hi ^ DP_POL;
    an_d   = an_hi ^ AN_POL;
    tick_d = (state_d == SNAP);
  end

  // Control state and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
    end
  end

  // Output registers; reset drives the display dark immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_POL;
      dp_q   <= DP_POL;
      an_q   <= AN_POL;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: two instances (BLANK=2 and
// BLANK=0) share stimulus and are compared each cycle against a frame-phase
// reference model, plus a table of per-digit glyph vectors and hand-written
// corner-case sequences.
module tb_bcd_display_scan;

  localparam int D     = 4;
  localparam int P     = 10;
  localparam int B     = 2;
  localparam int FRAME = D * P + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        ft_a, ft_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.DIGITS(D), .PRESCALE(P), .BLANK(B), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
  );

  bcd_display_scan #(.DIGITS(D), .PRESCALE(P), .BLANK(0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b)
  );

  // Reference model: position within the frame (-1 = not scanning) and the
  // inputs captured at the frame start.
  int          phase = -1;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;

  // Active-low pin glyphs for codes 0..F (A-F show a dash).
  logic [6:0] glyph_al [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dpi;
    logic        lz;
    logic [27:0] exp_seg;  // {digit3, digit2, digit1, digit0}, active-low
  } vec_t;

  vec_t tv [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t phase=%0d", name, act, exp, $time, phase);
    end
  endtask

  // Expected pins for the current frame phase, for a given blank length.
  function automatic void model_out(input int blank, output logic [3:0] e_an,
                                    output logic [6:0] e_seg, output logic e_dp,
                                    output logic e_ft);
    int s, w, k, msnz;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_ft  = (phase == 0);
    if (phase >= 1) begin
      s = (phase - 1) / P;
      w = (phase - 1) % P;
      k = D - 1 - s;
      if (w >= blank) begin
        msnz = 0;
        for (int j = 0; j < D; j++) if (m_dig[4*j +: 4] != 4'd0) msnz = j;
        e_an  = ~(4'(1) << k);
        e_seg = (m_lz && k > msnz) ? 7'h7F : glyph_al[m_dig[4*k +: 4]];
        e_dp  = ~m_dp[k];
      end
    end
  endfunction

  // One clock: advance the model at the edge, compare both DUTs mid-cycle.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    @(posedge clk);
    if (!rst_n || !en) phase = -1;
    else if (phase < 0) phase = 0;
    else phase = (phase + 1) % FRAME;
    if (phase == 0) begin
      m_dig = digits;
      m_dp  = dp_in;
      m_lz  = lz_blank;
    end
    @(negedge clk);
    model_out(B, e_an, e_seg, e_dp, e_ft);
    check("an_a", an_a, e_an);
    check("seg_a", seg_a, e_seg);
    check("dp_a", dp_a, e_dp);
    check("tick_a", ft_a, e_ft);
    model_out(0, e_an, e_seg, e_dp, e_ft);
    check("an_b", an_b, e_an);
    check("seg_b", seg_b, e_seg);
    check("dp_b", dp_b, e_dp);
    check("tick_b", ft_b, e_ft);
  endtask

  // Step at least once, then until the model reaches the target phase.
  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (phase != target && n < 3 * FRAME);
    check("run_to_timeout", phase, target);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an_a"}, an_a, 4'hF);
    check({tag, "_seg_a"}, seg_a, 7'h7F);
    check({tag, "_dp_a"}, dp_a, 1'b1);
    check({tag, "_tick_a"}, ft_a, 1'b0);
    check({tag, "_an_b"}, an_b, 4'hF);
    check({tag, "_seg_b"}, seg_b, 7'h7F);
  endtask

  initial begin
    int n, darks, w, k;
    logic e_dp;

    tv[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tv[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}};
    tv[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tv[3] = '{16'hA5F9, 4'b0100, 1'b0, {7'h3F, 7'h12, 7'h3F, 7'h10}};
    tv[4] = '{16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}};
    tv[5] = '{16'h0800, 4'b0001, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}};
    tv[6] = '{16'h0005, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};

    // Reset state.
    repeat (2) @(negedge clk);
    check_dark("reset");
    $display("reset: an=%b seg=%h dp=%b tick=%b", an_a, seg_a, dp_a, ft_a);
    rst_n = 1'b1;
    repeat (3) step();
    $display("idle with en=0: an=%b", an_a);

    // Table-driven glyph vectors, checked on the first lit cycle of each digit.
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      digits   = tv[i].dig;
      dp_in    = tv[i].dpi;
      lz_blank = tv[i].lz;
      run_to(0);
      for (int p = 1; p < FRAME; p++) begin
        step();
        w = (p - 1) % P;
        k = D - 1 - (p - 1) / P;
        if (w == B) begin
          e_dp = ~tv[i].dpi[k];
          check("vec_seg", seg_a, tv[i].exp_seg[7*k +: 7]);
          check("vec_dp", dp_a, e_dp);
        end
      end
      $display("vector %0d: digits=%h dp_in=%b lz=%b errors so far=%0d",
               i, tv[i].dig, tv[i].dpi, tv[i].lz, errors);
    end

    // Frame period measured between frame_tick pulses.
    digits = 16'h1234; dp_in = '0; lz_blank = 1'b0;
    run_to(0);
    n = 0;
    do begin
      step();
      n++;
    end while (!ft_a && n < 100);
    check("tick_period", n, FRAME);
    $display("frame period: %0d cycles", n);

    // Tearing: change inputs during digit 2 SHOW.
    digits = 16'h1111;
    run_to(0);
    run_to(14);
    digits = 16'h2222;
    run_to(35);
    check("tear_same_frame", seg_a, 7'h79);
    run_to(3);
    check("tear_next_frame", seg_a, 7'h24);
    $display("tearing: old frame kept '1', new frame shows '2'");

    // Enable drop during digit 1 SHOW, then re-raise.
    run_to(25);
    en = 1'b0;
    step();
    check("en_drop_an", an_a, 4'hF);
    step();
    en = 1'b1;
    step();
    check("en_snap_tick", ft_a, 1'b1);
    run_to(3);
    check("en_first_digit", an_a, 4'b0111);
    $display("enable drop/raise: restart at digit 3");

    // BLANK=0 build: no dark cycles between digits.
    run_to(0);
    darks = 0;
    for (int p = 1; p < FRAME; p++) begin
      step();
      if (an_b == 4'hF) darks++;
    end
    check("blank0_dark_cycles", darks, 0);
    $display("blank=0 build: dark cycles in frame=%0d", darks);

    // Randomized stimulus against the model, with occasional enable drops.
    for (int r = 0; r < 10; r++) begin
      digits   = 16'($urandom());
      dp_in    = 4'($urandom());
      lz_blank = 1'($urandom());
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        en = 1'b1;
      end
      repeat ($urandom_range(20, 90)) step();
      $display("random %0d: digits=%h dp_in=%b lz=%b errors so far=%0d",
               r, digits, dp_in, lz_blank, errors);
    end

    // Asynchronous reset in the middle of a lit slot.
    run_to(5);
    #2 rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    phase = -1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_tick", ft_a, 1'b1);
    repeat (FRAME) step();
    $display("async reset mid-show: dark at once, restart with snapshot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
